// File: rtl/reg_writeback.sv
// reg_writeback: ordered write-back queue in front of the register bank.
// ALU and load results are queued in acceptance order and drained one per
// cycle onto the bank write port; in-flight values are exposed to decode
// through the rs1/rs2 forwarding outputs.
module reg_writeback #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              wb_stall,
  input  logic [31:0]       instruction,
  output logic              write_en,
  output logic [4:0]        write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Queue storage and bookkeeping
  logic [4:0]        rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Bank write-port registers
  logic              write_en_q;
  logic [4:0]        write_address_q;
  logic [DATA_W-1:0] write_data_q;

  // Handshake / push / pop controls
  logic              not_full_s;
  logic              mem_fire_s;
  logic              alu_fire_s;
  logic              push_en_s;
  logic              pop_en_s;
  logic [4:0]        push_rd_s;
  logic [DATA_W-1:0] push_data_s;

  // Forwarding
  logic [4:0]        rs1_s, rs2_s;
  logic [DATA_W:0]   fwd1_s, fwd2_s;
  logic              unused_instr_bits_s;

  // Keep the current best forwarding candidate unless a newer one matches.
  function automatic logic [DATA_W:0] fwd_pick(input logic [DATA_W:0]   cur,
                                               input logic              match,
                                               input logic [DATA_W-1:0] cand);
    if (match) begin
      fwd_pick = {1'b1, cand};
    end else begin
      fwd_pick = cur;
    end
  endfunction

  assign rs1_s = instruction[19:15];
  assign rs2_s = instruction[24:20];
  assign unused_instr_bits_s = ^{instruction[31:25], instruction[14:0]};

  // Ready is derived from registered occupancy only; the load unit wins ties.
  always_comb begin
    not_full_s  = (count_q < DEPTH_C);
    mem_ready   = not_full_s;
    alu_ready   = not_full_s & ~mem_valid;
    mem_fire_s  = mem_valid & not_full_s;
    alu_fire_s  = alu_valid & not_full_s & ~mem_valid;
    if (mem_fire_s) begin
      push_rd_s   = mem_rd;
      push_data_s = mem_data;
    end else if (alu_fire_s) begin
      push_rd_s   = alu_rd;
      push_data_s = alu_data;
    end else begin
      push_rd_s   = 5'd0;
      push_data_s = '0;
    end
    // x0 results complete the handshake but are never queued
    push_en_s = (mem_fire_s | alu_fire_s) & (push_rd_s != 5'd0);
    pop_en_s  = (count_q != {CNT_W{1'b0}}) & ~wb_stall;
  end

  // Next-state pointers and occupancy
  always_comb begin
    if (pop_en_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    if (push_en_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state, entry writes and the bank write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      write_en_q      <= 1'b0;
      write_address_q <= 5'd0;
      write_data_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_en_s) begin
        rd_q[tail_q]   <= push_rd_s;
        data_q[tail_q] <= push_data_s;
      end
      if (pop_en_s) begin
        write_en_q      <= 1'b1;
        write_address_q <= rd_q[head_q];
        write_data_q    <= data_q[head_q];
      end else begin
        write_en_q      <= 1'b0;
      end
    end
  end

  // Forwarding: output register is the oldest candidate, queue entries are
  // scanned head to tail so the youngest match ends up winning.
  always_comb begin
    fwd1_s = '0;
    fwd2_s = '0;
    fwd1_s = fwd_pick(fwd1_s, write_en_q && (write_address_q == rs1_s), write_data_q);
    fwd2_s = fwd_pick(fwd2_s, write_en_q && (write_address_q == rs2_s), write_data_q);
    for (int i = 0; i < DEPTH; i++) begin
      fwd1_s = fwd_pick(fwd1_s,
                        (CNT_W'(i) < count_q) && (rd_q[head_q + PTR_W'(i)] == rs1_s),
                        data_q[head_q + PTR_W'(i)]);
      fwd2_s = fwd_pick(fwd2_s,
                        (CNT_W'(i) < count_q) && (rd_q[head_q + PTR_W'(i)] == rs2_s),
                        data_q[head_q + PTR_W'(i)]);
    end
    // x0 is never in flight
    if (rs1_s == 5'd0) begin
      fwd1_s = '0;
    end else begin
      fwd1_s = fwd1_s;
    end
    if (rs2_s == 5'd0) begin
      fwd2_s = '0;
    end else begin
      fwd2_s = fwd2_s;
    end
  end

  assign fwd_hit1      = fwd1_s[DATA_W];
  assign fwd_data1     = fwd1_s[DATA_W-1:0];
  assign fwd_hit2      = fwd2_s[DATA_W];
  assign fwd_data2     = fwd2_s[DATA_W-1:0];
  assign write_en      = write_en_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign count         = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_reg_writeback;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wb_stall;
  logic [31:0]       instruction;
  logic              write_en;
  logic [4:0]        write_address;
  logic [DATA_W-1:0] write_data;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  reg_writeback #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .instruction(instruction),
    .write_en(write_en), .write_address(write_address), .write_data(write_data),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: in-flight entries as {rd, data}, oldest first
  logic [68:0] mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = 5'd0;
  logic [63:0] m_wd = 64'd0;
  bit          known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] rs, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = 64'd0;
    if (rs != 5'd0) begin
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (!hit && mq[k][68:64] == rs) begin
          hit = 1'b1;
          d   = mq[k][63:0];
        end
      end
      if (!hit && m_we && m_wa == rs) begin
        hit = 1'b1;
        d   = m_wd;
      end
    end
  endfunction

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 64'd0;
  endtask

  // One clock: check combinational outputs, advance the model, check registers
  task automatic cycle();
    logic        e_mr, e_ar, h;
    logic [63:0] d;
    logic        acc;
    logic [4:0]  prd;
    logic [63:0] pdata;
    #2;
    e_mr = (mq.size() < DEPTH);
    e_ar = e_mr && !mem_valid;
    if (known) begin
      check("mem_ready", 64'(mem_ready), 64'(e_mr));
      check("alu_ready", 64'(alu_ready), 64'(e_ar));
      fwd_model(instruction[19:15], h, d);
      check("fwd_hit1", 64'(fwd_hit1), 64'(h));
      check("fwd_data1", fwd_data1, d);
      fwd_model(instruction[24:20], h, d);
      check("fwd_hit2", 64'(fwd_hit2), 64'(h));
      check("fwd_data2", fwd_data2, d);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_wa = 5'd0; m_wd = 64'd0;
      known = 1'b1;
    end else begin
      acc = 1'b0; prd = 5'd0; pdata = 64'd0;
      if (mem_valid && e_mr) begin
        acc = 1'b1; prd = mem_rd; pdata = mem_data;
      end else if (alu_valid && e_ar) begin
        acc = 1'b1; prd = alu_rd; pdata = alu_data;
      end
      if (mq.size() > 0 && !wb_stall) begin
        m_we = 1'b1;
        m_wa = mq[0][68:64];
        m_wd = mq[0][63:0];
        void'(mq.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (acc && prd != 5'd0) mq.push_back({prd, pdata});
    end
    #1;
    if (known) begin
      check("write_en", 64'(write_en), 64'(m_we));
      check("write_address", 64'(write_address), 64'(m_wa));
      check("write_data", write_data, m_wd);
      check("count", 64'(count), 64'(mq.size()));
    end
  endtask

  initial begin
    rst = 1'b1; idle(); wb_stall = 1'b0; instruction = 32'd0;
    cycle(); cycle();
    rst = 1'b0;
    check("reset_count", 64'(count), 64'd0);
    check("reset_we", 64'(write_en), 64'd0);

    // Single write: visible on the bank port one edge after acceptance
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    cycle();
    idle();
    cycle();
    check("single_we", 64'(write_en), 64'd1);
    check("single_addr", 64'(write_address), 64'd5);
    check("single_data", write_data, 64'h1234);
    cycle();
    check("single_we_off", 64'(write_en), 64'd0);
    check("single_count", 64'(count), 64'd0);

    // Priority: load wins, ALU follows next cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h44;
    #1;
    check("prio_alu_ready", 64'(alu_ready), 64'd0);
    cycle();
    mem_valid = 1'b0;
    cycle();
    check("prio_first", 64'(write_address), 64'd4);
    idle();
    cycle();
    check("prio_second", 64'(write_address), 64'd3);
    cycle();

    // Full under stall, then drain in order
    wb_stall = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      alu_valid = 1'b1; alu_rd = 5'(r); alu_data = 64'(r * 256);
      cycle();
    end
    check("full_count", 64'(count), 64'd4);
    wb_stall = 1'b0;
    cycle();
    check("drain_first", 64'(write_address), 64'd1);
    cycle();
    idle();
    for (int k = 0; k < 5; k++) cycle();

    // x0 result is dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
    cycle();
    idle();
    cycle();
    check("x0_count", 64'(count), 64'd0);
    check("x0_we", 64'(write_en), 64'd0);

    // Forwarding picks the youngest of two same-rd entries
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA;
    cycle();
    alu_data = 64'hB;
    cycle();
    idle();
    instruction = 32'h0003_8000;
    #1;
    check("fwd_dir_hit1", 64'(fwd_hit1), 64'd1);
    check("fwd_dir_data1", fwd_data1, 64'hB);
    check("fwd_dir_hit2", 64'(fwd_hit2), 64'd0);

    // Reset with entries in flight
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    cycle();
    check("pre_rst_count", 64'(count), 64'd3);
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; wb_stall = 1'b0;
    check("rst_mid_count", 64'(count), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rst_mid_no_we", 64'(write_en), 64'd0);
    end

    // Random phase with alternating stall-heavy and drain-heavy windows
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rd    = 5'($urandom_range(0, 7));
      mem_data  = {$urandom, $urandom};
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = {$urandom, $urandom};
      if ((i % 100) < 50) wb_stall = ($urandom_range(0, 3) != 0);
      else                wb_stall = ($urandom_range(0, 3) == 0);
      instruction        = $urandom;
      instruction[19:15] = 5'($urandom_range(0, 7));
      instruction[24:20] = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
